// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator and the decoder that drives it.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_ERET = 3'd4
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IMEM_BYTES_DEF = 32'h0000_4000;

endpackage

// File: rtl/pc_gen_if.sv
// Decode-stage control in, fetch PC, flags and debug counters out.
interface pc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic [2:0]        npc_op;
    logic              br_taken;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] rs_val;
    logic [ADDR_W-1:0] epc;
    logic              exc_req;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] pc_f4;
    logic              fetch_adel;
    logic              bd_f;
    logic              flush_f;
    logic              redirect;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  redir_cnt;

    modport master (
        output stall, npc_op, br_taken, pc_d, imm16, imm26, rs_val, epc, exc_req,
        input  pc_f, pc_f4, fetch_adel, bd_f, flush_f, redirect, fetch_cnt, redir_cnt
    );

    modport slave (
        input  stall, npc_op, br_taken, pc_d, imm16, imm26, rs_val, epc, exc_req,
        output pc_f, pc_f4, fetch_adel, bd_f, flush_f, redirect, fetch_cnt, redir_cnt
    );
endinterface

// File: rtl/pc_gen_npc_target.sv
// Combinational redirect target: branch, jump, register jump or eret, all relative to pc_d.
module pc_gen_npc_target
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  npc_op_e           npc_op,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] target
);
    localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] pc_d4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] j_tgt;

    assign pc_d4  = pc_d + ADDR_W'(4);
    assign br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    // Mask form keeps the region bits correct even when ADDR_W is exactly 28.
    assign j_tgt  = (pc_d4 & ~LOW28) | ADDR_W'({imm26, 2'b00});

    always_comb begin
        target = pc_d4 + br_off;
        case (npc_op)
            NPC_J:    target = j_tgt;
            NPC_JR:   target = rs_val;
            NPC_ERET: target = epc;
            default:  target = pc_d4 + br_off;
        endcase
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with exception/stall/redirect priority, fetch flags and saturating debug counters.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(PC_RESET_DEF),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
    parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(IMEM_BASE_DEF),
    parameter logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_BYTES_DEF),
    parameter bit                DELAY_SLOT = 1'b1,
    parameter int                CNT_W      = 32
) (
    input logic     clk,
    input logic     reset,
    pc_gen_if.slave bus
);
    // One extra bit so a window touching the top of the address space does not wrap.
    localparam logic [ADDR_W:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    npc_op_e           op;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  fetch_q;
    logic [CNT_W-1:0]  redir_q;
    logic              is_eret;
    logic              is_ctl;
    logic              advance;

    assign op      = npc_op_e'(bus.npc_op);
    assign is_eret = (op == NPC_ERET);
    assign is_ctl  = ((op == NPC_BR) && bus.br_taken) || (op == NPC_J) || (op == NPC_JR);
    assign advance = !bus.stall || bus.exc_req;

    pc_gen_npc_target #(.ADDR_W(ADDR_W)) u_target (
        .npc_op (op),
        .pc_d   (bus.pc_d),
        .imm16  (bus.imm16),
        .imm26  (bus.imm26),
        .rs_val (bus.rs_val),
        .epc    (bus.epc),
        .target (target)
    );

    always_comb begin
        pc_next = pc_q + ADDR_W'(4);
        if (bus.exc_req)
            pc_next = EXC_VECTOR;
        else if (bus.stall)
            pc_next = pc_q;
        else if (is_eret || is_ctl)
            pc_next = target;
    end

    assign bus.redirect = bus.exc_req || (!bus.stall && (is_eret || is_ctl));
    assign bus.flush_f  = bus.exc_req || (!bus.stall && is_eret)
                          || (!DELAY_SLOT && !bus.stall && is_ctl);
    // A not-taken branch still owns its slot, so br_taken is deliberately ignored.
    assign bus.bd_f     = DELAY_SLOT && ((op == NPC_BR) || (op == NPC_J) || (op == NPC_JR));

    assign bus.pc_f       = pc_q;
    assign bus.pc_f4      = pc_q + ADDR_W'(4);
    assign bus.fetch_adel = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE)
                            || ({1'b0, pc_q} >= IMEM_END);
    assign bus.fetch_cnt  = fetch_q;
    assign bus.redir_cnt  = redir_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= PC_RESET;
            fetch_q <= '0;
            redir_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (advance && (fetch_q != '1))
                fetch_q <= fetch_q + CNT_W'(1);
            if (bus.redirect && (redir_q != '1))
                redir_q <= redir_q + CNT_W'(1);
        end
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-stage PC generator for the pipelined MIPS core: the successor of the single-cycle NPC logic.
- Owns the PC register and computes the next PC from decode-stage control (branch, j/jal, jr/jalr, eret), exception entry and stall.
- Delay-slot semantics are parametrisable.
- Exports fetch-address fault and delay-slot flags to the exception path, plus saturating fetch and redirect counters for debug.

Parameters:
- ADDR_W, 32, PC/address width; must be ≥ 28.
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_4000, size of the legal fetch window.
- DELAY_SLOT, 1, 1 = MIPS branch delay slot; 0 = fetched instruction is killed on redirect.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets)
- stall  in  1  hold PC (hazard unit)
- npc_op  in  3  0 SEQ, 1 BR, 2 J, 3 JR, 4 ERET; 5-7 treated as SEQ
- br_taken  in  1  branch condition from D-stage comparator; used only when npc_op==BR
- pc_d  in  ADDR_W  PC of the instruction in D
- imm16  in  16  branch offset
- imm26  in  26  jump index
- rs_val  in  ADDR_W  forwarded GPR value for JR
- epc  in  ADDR_W  CP0 EPC for ERET
- exc_req  in  1  exception/interrupt accepted this cycle
- pc_f  out  ADDR_W  current fetch PC (register)
- pc_f4  out  ADDR_W  pc_f+4
- fetch_adel  out  1  pc_f misaligned or outside [IMEM_BASE, IMEM_BASE+IMEM_BYTES)
- bd_f  out  1  instruction at pc_f is a delay slot
- flush_f  out  1  kill the instruction at pc_f (F/D register loads a NOP)
- redirect  out  1  non-sequential next PC selected this cycle
- fetch_cnt  out  CNT_W  cycles in which the PC advanced
- redir_cnt  out  CNT_W  cycles with redirect==1

Behaviour:
- Reset (reset==0 at a clk edge): pc_f=PC_RESET and both counters=0, regardless of every other input.
- Combinational outputs follow from the reset state: pc_f4=PC_RESET+4, fetch_adel=0 for the defaults.
- Targets are all computed from pc_d; arithmetic is modulo 2^ADDR_W:
  - BR: pc_d+4+(sext(imm16)<<2)
  - J: {(pc_d+4)[ADDR_W-1:28], imm26, 2'b00}
  - JR: rs_val, unmodified; misalignment is reported next cycle via fetch_adel
  - ERET: epc
- Next-PC priority, highest first:
  - exc_req → EXC_VECTOR; this overrides stall.
  - stall → hold pc_f.
  - ERET → epc.
  - BR with br_taken, J, or JR → target.
  - otherwise → pc_f+4. This includes BR with br_taken==0.
- redirect=1 when exc_req, or when !stall and (ERET, taken BR, J or JR). It is combinational, same cycle as the selection.
- flush_f:
  - 1 on exc_req or (!stall & ERET), because eret has no delay slot.
  - With DELAY_SLOT==0, additionally 1 on (!stall & taken BR/J/JR).
  - Never asserted by stall alone.
- bd_f:
  - With DELAY_SLOT==1: bd_f = (npc_op ∈ {BR,J,JR}), independent of br_taken, because a not-taken branch still owns a slot.
  - With DELAY_SLOT==0: bd_f is tied 0.
- fetch_adel is combinational on pc_f. The PC still advances normally; the exception unit reacts via exc_req.
- PC update happens only at the clk edge; single-cycle latency from select to pc_f.
- Counters:
  - fetch_cnt increments when pc_f changes value or is reloaded (i.e. !stall or exc_req).
  - redir_cnt increments when redirect==1.
  - Both saturate at all-ones and never wrap.
- Simultaneous exc_req and ERET: exception wins, pc_f=EXC_VECTOR.
- Reset asserted mid-stall or mid-redirect: reset wins.

Decomposition:
- Shared package holds npc_op encodings (NPC_SEQ..NPC_ERET) and the default PC_RESET/EXC_VECTOR constants; the decoder uses the same package.
- One sub-module, npc_target: purely combinational target computation (BR/J/JR/ERET mux).
- pc_gen keeps the register, priority, flags and counters.

Test Plan:
- Reset and run:
  - hold reset=0 two cycles → pc_f=0x3000, counters 0;
  - release with npc_op=SEQ for 3 cycles → pc_f 0x3004, 0x3008, 0x300C; fetch_cnt=3.
- Taken branch backward:
  - pc_d=0x3010, npc_op=BR, br_taken=1, imm16=0xFFFC → next pc_f=0x3004;
  - redirect=1, bd_f=1; flush_f=0 (DELAY_SLOT=1), flush_f=1 (DELAY_SLOT=0).
- Stall then JR misaligned:
  - stall=1 for 2 cycles with npc_op=J → pc_f unchanged, redirect=0, fetch_cnt unchanged;
  - then npc_op=JR, rs_val=0x3022 → pc_f=0x3022, fetch_adel=1.
- Exception beats stall and ERET:
  - stall=1, npc_op=ERET, exc_req=1 → pc_f=0x4180, flush_f=1;
  - next cycle ERET with epc=0x3040 → pc_f=0x3040, flush_f=1, bd_f=0.
- Counter saturation: CNT_W=4, 20 SEQ cycles → fetch_cnt stays 15.
- Jump region: pc_d=0x3FFC, npc_op=J, imm26=0x0000C10 → pc_f=0x0000_3040.
